// File: rtl/rv64_alu_regfile.sv
// rv64_alu_regfile: 32x64 integer register file with a 64-bit combinational ALU
module rv64_alu_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr1,
    output logic [63:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [63:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [63:0] wdata,
    input  logic [63:0] src1,
    input  logic [63:0] src2,
    input  logic [1:0]  aluop,
    output logic [63:0] result
);
    logic [63:0] regs_q [32];
    // register storage: async clear, x0 writes dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            regs_q[waddr] <= wdata;
        end
    end
    // combinational reads with hardwired x0, ALU select
    always_comb begin
        rdata1 = raddr1 == 5'd0 ? 64'd0 : regs_q[raddr1];
        rdata2 = raddr2 == 5'd0 ? 64'd0 : regs_q[raddr2];
        result = aluop == 2'b00 ? src2 :
                 aluop == 2'b01 ? src1 + src2 :
                 aluop == 2'b10 ? {63'd0, src1 < src2} : 64'd0;
    end
endmodule

// File: tb/tb_rv64_alu_regfile.sv
// tb_rv64_alu_regfile: vectors, corner sequences and randomized model check
module tb_rv64_alu_regfile;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  raddr1 = '0, raddr2 = '0, waddr = '0;
    logic        we = 1'b0;
    logic [63:0] wdata = '0, src1 = '0, src2 = '0;
    logic [1:0]  aluop = '0;
    logic [63:0] rdata1, rdata2, result;
    int checks = 0;
    int errors = 0;
    logic [63:0] mdl [32];

    rv64_alu_regfile dut (
        .clk(clk), .rst(rst),
        .raddr1(raddr1), .rdata1(rdata1),
        .raddr2(raddr2), .rdata2(rdata2),
        .we(we), .waddr(waddr), .wdata(wdata),
        .src1(src1), .src2(src2), .aluop(aluop), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } alu_vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] alu_ref(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        case (op)
            2'd0: return b;
            2'd1: return 64'(ua + ub);
            2'd2: return (ua < ub) ? 64'd1 : 64'd0;
            default: return 64'd0;
        endcase
    endfunction

    task automatic write_reg(input logic [4:0] a, input logic [63:0] d);
        @(negedge clk);
        we = 1'b1; waddr = a; wdata = d;
        @(posedge clk);
        #1 we = 1'b0;
    endtask

    alu_vec_t vecs [10];

    initial begin
        vecs[0] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
        vecs[1] = '{2'b01, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_7FFF_FFFC};
        vecs[2] = '{2'b10, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
        vecs[3] = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
        vecs[4] = '{2'b10, 64'd7, 64'd7, 64'd0};
        vecs[5] = '{2'b00, 64'h1234, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000};
        vecs[6] = '{2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        vecs[7] = '{2'b01, 64'd100, 64'd23, 64'd123};
        vecs[8] = '{2'b10, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0};
        vecs[9] = '{2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd1};

        // reset state: every address reads 0 on both ports
        #12;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i); raddr2 = 5'(31 - i);
            #1;
            chk("reset_rd1", rdata1, 64'd0);
            chk("reset_rd2", rdata2, 64'd0);
        end
        @(negedge clk) rst = 1'b0;

        // ALU table
        for (int i = 0; i < 10; i++) begin
            aluop = vecs[i].op; src1 = vecs[i].a; src2 = vecs[i].b;
            #1 chk("alu_vec", result, vecs[i].exp);
        end

        // async reset clears x5 without a clock edge
        write_reg(5'd5, 64'hDEAD);
        raddr1 = 5'd5;
        #1 chk("x5_dead", rdata1, 64'hDEAD);
        @(negedge clk) #2 rst = 1'b1;
        #1 chk("async_rst_x5", rdata1, 64'd0);
        for (int i = 1; i < 32; i++) begin
            raddr2 = 5'(i);
            #0.1 chk("async_rst_all", rdata2, 64'd0);
        end

        // write coinciding with reset is lost
        we = 1'b1; waddr = 5'd6; wdata = 64'hABCD;
        @(posedge clk) #1 we = 1'b0;
        raddr1 = 5'd6;
        #1 chk("wr_during_rst", rdata1, 64'd0);
        @(negedge clk) rst = 1'b0;

        // write/read latency: old value before edge, new after
        @(negedge clk);
        we = 1'b1; waddr = 5'd5; wdata = 64'h0000_0000_8000_1234;
        raddr1 = 5'd5; raddr2 = 5'd5;
        #1 chk("pre_edge_x5", rdata1, 64'd0);
        @(posedge clk) #1;
        chk("post_edge_x5_p1", rdata1, 64'h8000_1234);
        chk("post_edge_x5_p2", rdata2, 64'h8000_1234);
        we = 1'b0; wdata = 64'h1111;
        @(posedge clk) #1 chk("we0_hold", rdata1, 64'h8000_1234);

        // x0 ignores writes, x31 holds all ones
        write_reg(5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        raddr1 = 5'd0;
        #1 chk("x0_zero", rdata1, 64'd0);
        write_reg(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        raddr2 = 5'd31;
        #1 chk("x31_ones", rdata2, 64'hFFFF_FFFF_FFFF_FFFF);

        // randomized run against a behavioural model
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        mdl[5] = 64'h8000_1234;
        mdl[31] = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 59) == 0);
            we = 1'($urandom);
            waddr = 5'($urandom);
            wdata = {$urandom, $urandom};
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            raddr2 = 5'($urandom);
            aluop = 2'($urandom);
            src1 = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 15));
            src2 = ($urandom_range(0, 3) == 0) ? src1 : {$urandom, $urandom};
            if (rst) for (int i = 0; i < 32; i++) mdl[i] = '0;
            #1;
            chk("rnd_rd1", rdata1, raddr1 == 0 ? 64'd0 : mdl[raddr1]);
            chk("rnd_rd2", rdata2, raddr2 == 0 ? 64'd0 : mdl[raddr2]);
            chk("rnd_alu", result, alu_ref(aluop, src1, src2));
            @(posedge clk);
            if (!rst && we && waddr != 0) mdl[waddr] = wdata;
        end
        @(negedge clk) begin rst = 1'b0; we = 1'b0; end
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            #1 chk("final_sweep", rdata1, i == 0 ? 64'd0 : mdl[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
